// File: rtl/pipeline_pkg.sv
// Shared types and defaults for valid/ready pipeline stage registers.
package pipeline_pkg;

    // Encoding equals the number of held entries, so it doubles as the count output.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam int RV32E_RD_W     = 4;
    localparam int DATA_W_DEFAULT = 32;

endpackage

// File: rtl/pipeline_slot.sv
// One held pipeline entry: destination index, payload, write enable and valid.
module pipeline_slot #(
    parameter int RD_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [RD_W-1:0]   d_rd,
    input  logic [DATA_W-1:0] d_data,
    input  logic              d_we,
    output logic [RD_W-1:0]   q_rd,
    output logic [DATA_W-1:0] q_data,
    output logic              q_we,
    output logic              q_valid
);

    // Clear drops only the valid bit; the payload stays stable until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_rd    <= '0;
            q_data  <= '0;
            q_we    <= 1'b0;
            q_valid <= 1'b0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_rd    <= d_rd;
            q_data  <= d_data;
            q_we    <= d_we;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_register_skid.sv
// Skid-buffered valid/ready pipeline register with flush and youngest-first forwarding.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; valid never depends on ready.
module pipeline_register_skid
    import pipeline_pkg::*;
#(
    parameter int RD_W   = RV32E_RD_W,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    input  logic [RD_W-1:0]   fwd_rs,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        count
);

    stage_state_t st, st_next;

    logic in_fire, out_fire;
    logic main_load, main_clear, main_sel_skid;
    logic skid_load, skid_clear;
    logic in_ready_q;

    logic [RD_W-1:0]   main_rd,   skid_rd,   main_d_rd;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;
    logic              main_we,   skid_we,   main_d_we;
    logic              main_valid, skid_valid;
    logic              hit_main, hit_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            st         <= st_next;
            in_ready_q <= (st_next != FULL);
        end
    end

    always_comb begin
        st_next       = st;
        main_load     = 1'b0;
        main_clear    = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        if (flush) begin
            st_next    = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (st)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        st_next   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        st_next   = FULL;
                    end else if (out_fire) begin
                        main_clear = 1'b1;
                        st_next    = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain case can occur.
                    if (out_fire) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clear    = 1'b1;
                        st_next       = ONE;
                    end
                end
                default: st_next = EMPTY;
            endcase
        end
    end

    assign main_d_rd   = main_sel_skid ? skid_rd   : in_rd;
    assign main_d_data = main_sel_skid ? skid_data : in_data;
    assign main_d_we   = main_sel_skid ? skid_we   : in_we;

    pipeline_slot #(.RD_W(RD_W), .DATA_W(DATA_W)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .d_rd    (main_d_rd),
        .d_data  (main_d_data),
        .d_we    (main_d_we),
        .q_rd    (main_rd),
        .q_data  (main_data),
        .q_we    (main_we),
        .q_valid (main_valid)
    );

    pipeline_slot #(.RD_W(RD_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_rd    (in_rd),
        .d_data  (in_data),
        .d_we    (in_we),
        .q_rd    (skid_rd),
        .q_data  (skid_data),
        .q_we    (skid_we),
        .q_valid (skid_valid)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_rd    = main_rd;
    assign out_data  = main_data;
    assign out_we    = main_we & main_valid;
    assign count     = st;

    // x0 is hardwired, so a zero query never forwards.
    assign hit_skid = skid_valid & skid_we & (skid_rd == fwd_rs) & (fwd_rs != '0);
    assign hit_main = main_valid & main_we & (main_rd == fwd_rs) & (fwd_rs != '0);
    assign fwd_hit  = hit_skid | hit_main;
    assign fwd_data = hit_skid ? skid_data : (hit_main ? main_data : '0);

endmodule

// File: tb/tb_pipeline_register_skid.sv
// Directed bench for pipeline_register_skid with a FIFO scoreboard of accepted entries.
module tb_pipeline_register_skid;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rd;
    logic [31:0] in_data;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rd;
    logic [31:0] out_data;
    logic        out_we;
    logic [3:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [1:0]  count;

    logic [36:0] exp_q[$];
    int tests_run;
    int tests_failed;

    pipeline_register_skid #(.RD_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .in_we     (in_we),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .out_we    (out_we),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rd, input logic [31:0] data, input logic we);
        in_valid = v;
        in_rd    = rd;
        in_data  = data;
        in_we    = we;
    endtask

    // Score the handshakes of the coming edge, then advance to the next falling edge.
    task automatic cycle();
        logic [36:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {63'd0, out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_rd", {60'd0, out_rd}, {60'd0, e[35:32]});
                check("out_data", {32'd0, out_data}, {32'd0, e[31:0]});
                check("out_we", {63'd0, out_we}, {63'd0, e[36]});
            end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_we, in_rd, in_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_fwd(input logic [3:0] rs, input logic hit, input logic [31:0] data);
        fwd_rs = rs;
        #1;
        check("fwd_hit", {63'd0, fwd_hit}, {63'd0, hit});
        check("fwd_data", {32'd0, fwd_data}, {32'd0, data});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b0;
        fwd_rs       = 4'd0;
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        #1;
        repeat (2) @(negedge clk);
        check("rst_count", {62'd0, count}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_we", {63'd0, out_we}, 64'd0);
        check("rst_out_rd", {60'd0, out_rd}, 64'd0);
        check("rst_out_data", {32'd0, out_data}, 64'd0);
        rst_n = 1'b1;
        cycle();

        // Streaming at full rate.
        out_ready = 1'b1;
        drive(1'b1, 4'd3, 32'h11, 1'b1); cycle();
        check("stream_valid", {63'd0, out_valid}, 64'd1);
        check("stream_lat", {32'd0, out_data}, 64'h11);
        check("stream_cnt1", {62'd0, count}, 64'd1);
        drive(1'b1, 4'd5, 32'h22, 1'b1); cycle();
        check("stream_cnt2", {62'd0, count}, 64'd1);
        drive(1'b1, 4'd7, 32'h33, 1'b1); cycle();
        check("stream_cnt3", {62'd0, count}, 64'd1);
        check("stream_lat3", {32'd0, out_data}, 64'h33);
        drive(1'b0, 4'd0, 32'd0, 1'b0); cycle();
        check("stream_empty", {62'd0, count}, 64'd0);

        // Backpressure fills the skid slot and holds C upstream.
        drive(1'b1, 4'd1, 32'hAA, 1'b1); cycle();
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'hBB, 1'b0); cycle();
        check("bp_count", {62'd0, count}, 64'd2);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        drive(1'b1, 4'd3, 32'hCC, 1'b1); cycle();
        check("bp_hold_count", {62'd0, count}, 64'd2);
        check("bp_hold_data", {32'd0, out_data}, 64'hAA);
        out_ready = 1'b1;
        cycle();
        check("bp_ready_back", {63'd0, in_ready}, 64'd1);
        cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0); cycle();
        check("bp_drained", {62'd0, count}, 64'd0);

        // Flush while FULL with D offered upstream.
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 32'hE1, 1'b1); cycle();
        drive(1'b1, 4'd4, 32'hF2, 1'b1); cycle();
        check("fl_full", {62'd0, count}, 64'd2);
        flush = 1'b1;
        drive(1'b1, 4'd6, 32'hDD, 1'b1); cycle();
        flush = 1'b0;
        check("fl_count", {62'd0, count}, 64'd0);
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_in_ready", {63'd0, in_ready}, 64'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        out_ready = 1'b1;
        repeat (3) cycle();
        check("fl_no_d", {63'd0, out_valid}, 64'd0);

        // Flush in ONE: the delivered entry counts, the incoming one is discarded.
        drive(1'b1, 4'd8, 32'h77, 1'b1); cycle();
        flush = 1'b1;
        drive(1'b1, 4'd9, 32'h88, 1'b1); cycle();
        flush = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        check("fl1_count", {62'd0, count}, 64'd0);
        repeat (2) cycle();
        check("fl1_no_h", {63'd0, out_valid}, 64'd0);

        // Forwarding: skid is younger than main.
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'h10, 1'b1); cycle();
        drive(1'b1, 4'd5, 32'h20, 1'b1); cycle();
        drive(1'b1, 4'd5, 32'h55, 1'b1);
        check_fwd(4'd5, 1'b1, 32'h20);
        check_fwd(4'd0, 1'b0, 32'h0);
        check_fwd(4'd6, 1'b0, 32'h0);
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        out_ready = 1'b1;
        repeat (2) cycle();
        check_fwd(4'd5, 1'b0, 32'h0);
        out_ready = 1'b0;
        drive(1'b1, 4'd5, 32'h10, 1'b1); cycle();
        drive(1'b1, 4'd5, 32'h20, 1'b0); cycle();
        check_fwd(4'd5, 1'b1, 32'h10);
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        out_ready = 1'b1;
        repeat (2) cycle();

        // out_we gated once the entry has left.
        drive(1'b1, 4'd9, 32'h99, 1'b1); cycle();
        check("we_live", {63'd0, out_we}, 64'd1);
        drive(1'b0, 4'd0, 32'd0, 1'b0); cycle();
        check("we_count", {62'd0, count}, 64'd0);
        check("we_gated", {63'd0, out_we}, 64'd0);
        check_fwd(4'd9, 1'b0, 32'h0);

        // Asynchronous reset in the middle of a FULL stage.
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 32'h01, 1'b1); cycle();
        drive(1'b1, 4'd2, 32'h02, 1'b1); cycle();
        drive(1'b0, 4'd0, 32'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", {62'd0, count}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_out_data", {32'd0, out_data}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) cycle();
        check("end_queue", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
